// File: rtl/demux1a2_dest_pkg.sv
// Shared definitions for the 1:2 destination demultiplexer.
// Optional push counters are enabled with the DEMUX1A2_DEST_CNT_EN macro.
package demux1a2_dest_pkg;

    // Default word width and position of the destination-select bit.
    localparam int DATA_W_DEF   = 10;
    localparam int DEST_BIT_DEF = 8;

    // Width of the optional per-destination push counters.
    localparam int CNT_W = 8;

    // Destination FSM: IDLE accepts words, HOLD waits for the held word's FIFO.
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Select the almost-full flag belonging to a destination bit.
    function automatic logic dest_af(input logic dest, input logic af0, input logic af1);
        return dest ? af1 : af0;
    endfunction

endpackage

// File: rtl/demux1a2_dest_hold_reg.sv
// One-entry skid register: stores a word that could not be pushed, together
// with its destination bit and a valid flag.
module dest_hold_reg
    import demux1a2_dest_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    input  logic              dest_in,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              dest
);

    // Capture a blocked word on load; drop the valid flag once it has been pushed.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            valid <= 1'b0;
            data  <= '0;
            dest  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
            dest  <= dest_in;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux1a2_dest.sv
// 1:2 destination demultiplexer: routes each word to FIFO0 or FIFO1 by its
// destination bit, with a single skid slot for almost-full backpressure.
// Define DEMUX1A2_DEST_CNT_EN to add 8-bit wrapping push counters per FIFO.
module demux1a2_dest
    import demux1a2_dest_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEST_BIT = DEST_BIT_DEF
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] datain,
    output logic              ready_in,
    input  logic              almost_full0,
    input  logic              almost_full1,
    output logic              push0,
    output logic              push1,
    output logic [DATA_W-1:0] dataout_dest0,
    output logic [DATA_W-1:0] dataout_dest1
`ifdef DEMUX1A2_DEST_CNT_EN
    ,
    output logic [CNT_W-1:0]  cnt_dest0,
    output logic [CNT_W-1:0]  cnt_dest1
`endif
);

    state_t              state;
    logic                accept;
    logic                in_dest;
    logic                in_af;
    logic                hold_af;
    logic                hold_load;
    logic                hold_clear;
    logic                fire0;
    logic                fire1;
    logic [DATA_W-1:0]   push_word;
    logic                hold_valid;
    logic [DATA_W-1:0]   hold_data;
    logic                hold_dest;

    dest_hold_reg #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk     (clk),
        .reset_L (reset_L),
        .load    (hold_load),
        .clear   (hold_clear),
        .data_in (datain),
        .dest_in (in_dest),
        .valid   (hold_valid),
        .data    (hold_data),
        .dest    (hold_dest)
    );

    // Handshake, destination decode and the push decision for the coming edge.
    // NOTE: every signal gets a default at the top so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        ready_in   = 1'b0;
        accept     = 1'b0;
        in_dest    = 1'b0;
        in_af      = 1'b0;
        hold_af    = 1'b0;
        hold_load  = 1'b0;
        hold_clear = 1'b0;
        fire0      = 1'b0;
        fire1      = 1'b0;
        push_word  = datain;

        ready_in = (state == IDLE) && reset_L;
        accept   = valid_in && ready_in;
        in_dest  = datain[DEST_BIT];
        in_af    = dest_af(in_dest, almost_full0, almost_full1);
        hold_af  = dest_af(hold_dest, almost_full0, almost_full1);

        if (state == IDLE) begin
            // Only an accepted word is examined, so datain is don't-care otherwise.
            if (accept) begin
                hold_load = in_af;
                fire0     = !in_af && !in_dest;
                fire1     = !in_af &&  in_dest;
            end
        end else begin
            // The other FIFO's flag is ignored here so words never overtake.
            push_word  = hold_data;
            hold_clear = !hold_valid || !hold_af;
            fire0      = hold_valid && !hold_af && !hold_dest;
            fire1      = hold_valid && !hold_af &&  hold_dest;
        end
    end

    // Destination FSM with registered push strobes and data outputs.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state         <= IDLE;
            push0         <= 1'b0;
            push1         <= 1'b0;
            dataout_dest0 <= '0;
            dataout_dest1 <= '0;
        end else begin
            push0 <= fire0;
            push1 <= fire1;
            if (fire0) begin
                dataout_dest0 <= push_word;
            end
            if (fire1) begin
                dataout_dest1 <= push_word;
            end
            case (state)
                IDLE:    if (hold_load)  state <= HOLD;
                HOLD:    if (hold_clear) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DEMUX1A2_DEST_CNT_EN
    // Count pushes per destination; increments on the edge that raises the strobe.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt_dest0 <= '0;
            cnt_dest1 <= '0;
        end else begin
            if (fire0) begin
                cnt_dest0 <= cnt_dest0 + 1'b1;
            end
            if (fire1) begin
                cnt_dest1 <= cnt_dest1 + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux1a2_dest.sv
// Directed self-checking bench for demux1a2_dest.
module tb_demux1a2_dest;

    localparam int DATA_W = 10;

    logic              clk;
    logic              reset_L;
    logic              valid_in;
    logic [DATA_W-1:0] datain;
    logic              ready_in;
    logic              almost_full0;
    logic              almost_full1;
    logic              push0;
    logic              push1;
    logic [DATA_W-1:0] dataout_dest0;
    logic [DATA_W-1:0] dataout_dest1;
`ifdef DEMUX1A2_DEST_CNT_EN
    logic [7:0]        cnt_dest0;
    logic [7:0]        cnt_dest1;
`endif

    int n_checks = 0;
    int n_errors = 0;

    demux1a2_dest dut (
        .clk           (clk),
        .reset_L       (reset_L),
        .valid_in      (valid_in),
        .datain        (datain),
        .ready_in      (ready_in),
        .almost_full0  (almost_full0),
        .almost_full1  (almost_full1),
        .push0         (push0),
        .push1         (push1),
        .dataout_dest0 (dataout_dest0),
        .dataout_dest1 (dataout_dest1)
`ifdef DEMUX1A2_DEST_CNT_EN
        ,
        .cnt_dest0     (cnt_dest0),
        .cnt_dest1     (cnt_dest1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
        check("one_push_max", {31'd0, push0 & push1}, 32'd0);
    endtask

    task automatic expect_push(input string tag, input logic p0, input logic p1,
                               input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        check({tag, "_push0"}, {31'd0, push0}, {31'd0, p0});
        check({tag, "_push1"}, {31'd0, push1}, {31'd0, p1});
        check({tag, "_d0"}, {22'd0, dataout_dest0}, {22'd0, d0});
        check({tag, "_d1"}, {22'd0, dataout_dest1}, {22'd0, d1});
    endtask

    initial begin
        reset_L      = 1'b0;
        valid_in     = 1'b1;
        datain       = 10'h1FF;
        almost_full0 = 1'b0;
        almost_full1 = 1'b0;

        // Reset held two cycles with valid_in high.
        step();
        step();
        check("rst_ready", {31'd0, ready_in}, 32'd0);
        expect_push("rst", 1'b0, 1'b0, 10'h000, 10'h000);
        valid_in = 1'b0;
        reset_L  = 1'b1;
        #1;
        check("rel_ready", {31'd0, ready_in}, 32'd1);

        // Back-to-back stream alternating destinations.
        valid_in = 1'b1;
        datain = 10'h005; step(); expect_push("s0", 1'b1, 1'b0, 10'h005, 10'h000);
        datain = 10'h105; step(); expect_push("s1", 1'b0, 1'b1, 10'h005, 10'h105);
        datain = 10'h0AA; step(); expect_push("s2", 1'b1, 1'b0, 10'h0AA, 10'h105);
        datain = 10'h1FF; step(); expect_push("s3", 1'b0, 1'b1, 10'h0AA, 10'h1FF);
        valid_in = 1'b0;
        datain   = 'x;
        step(); expect_push("idle_x", 1'b0, 1'b0, 10'h0AA, 10'h1FF);

        // Backpressure on dest 1; a dest-0 word waits behind the held word.
        almost_full1 = 1'b1;
        valid_in     = 1'b1;
        datain       = 10'h123;
        step();
        check("hold_ready", {31'd0, ready_in}, 32'd0);
        expect_push("hold_in", 1'b0, 1'b0, 10'h0AA, 10'h1FF);
        datain = 10'h012;
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold_wait_ready", {31'd0, ready_in}, 32'd0);
            expect_push("hold_wait", 1'b0, 1'b0, 10'h0AA, 10'h1FF);
        end
        almost_full1 = 1'b0;
        step();
        expect_push("release", 1'b0, 1'b1, 10'h0AA, 10'h123);
        check("release_ready", {31'd0, ready_in}, 32'd1);
        step();
        expect_push("after_hold", 1'b1, 1'b0, 10'h012, 10'h123);
        valid_in = 1'b0;
        step();
        expect_push("drain", 1'b0, 1'b0, 10'h012, 10'h123);

        // Asynchronous reset while holding drops the held word.
        almost_full0 = 1'b1;
        valid_in     = 1'b1;
        datain       = 10'h033;
        step();
        check("hold0_ready", {31'd0, ready_in}, 32'd0);
        valid_in = 1'b0;
        #2;
        reset_L = 1'b0;
        #1;
        check("arst_ready", {31'd0, ready_in}, 32'd0);
        expect_push("arst", 1'b0, 1'b0, 10'h000, 10'h000);
        almost_full0 = 1'b0;
        step();
        reset_L = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_push("post_rst", 1'b0, 1'b0, 10'h000, 10'h000);
            check("post_rst_ready", {31'd0, ready_in}, 32'd1);
        end

`ifdef DEMUX1A2_DEST_CNT_EN
        check("cnt0_clr", {24'd0, cnt_dest0}, 32'd0);
        valid_in = 1'b1;
        datain   = 10'h055;
        step();
        check("cnt0_one", {24'd0, cnt_dest0}, 32'd1);
        for (int i = 1; i < 256; i++) begin
            step();
        end
        valid_in = 1'b0;
        step();
        check("cnt0_wrap", {24'd0, cnt_dest0}, 32'd0);
        check("cnt1_zero", {24'd0, cnt_dest1}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
